// File: rtl/operand_fetch_sel_if.sv
// Request/response bundle for operand_fetch_sel: request handshake in, operand beat stream out.
interface operand_fetch_sel_if #(
  parameter int NR_OF_BITS = 16,
  parameter int SEL_BITS   = 3,
  parameter int LEN_BITS   = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [SEL_BITS-1:0]   req_sel;
  logic [LEN_BITS-1:0]   req_len;
  logic [NR_OF_BITS-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [SEL_BITS-1:0]   out_idx;
  logic                  sel_error;

  modport master (
    output req_valid, req_sel, req_len, out_ready,
    input  req_ready, out_data, out_valid, out_last, out_idx, sel_error
  );

  modport slave (
    input  req_valid, req_sel, req_len, out_ready,
    output req_ready, out_data, out_valid, out_last, out_idx, sel_error
  );
endinterface

// File: rtl/operand_fetch_sel.sv
// Burst operand fetcher: streams source registers starting at req_sel, wrapping
// modulo NR_OF_SOURCES, one registered beat per accepted output handshake.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// XFER    | out_valid high, streaming beats until the counter-zero beat is taken
module operand_fetch_sel #(
  parameter int NR_OF_BITS    = 16,
  parameter int NR_OF_SOURCES = 8,
  parameter int SEL_BITS      = 3,
  parameter int LEN_BITS      = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NR_OF_SOURCES*NR_OF_BITS-1:0] reg_in_i,
  operand_fetch_sel_if.slave                  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;
  localparam logic [SEL_BITS:0] NR_SRC_W = (SEL_BITS+1)'(NR_OF_SOURCES);

  logic [0:0]            state_q, state_d;
  logic [LEN_BITS-1:0]   cnt_q, cnt_d;
  logic [NR_OF_BITS-1:0] data_q, data_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  consume;
  logic [SEL_BITS:0]     idx_inc;
  logic [SEL_BITS:0]     idx_wrap;
  logic [SEL_BITS-1:0]   fetch_idx;
  logic [NR_OF_BITS-1:0] fetch_data;
  logic                  fetch_oor;

  assign accept    = (state_q == ST_IDLE) && bus.req_valid;
  assign consume   = valid_q && bus.out_ready;
  assign idx_inc   = {1'b0, idx_q} + 1'b1;
  assign idx_wrap  = idx_inc % NR_SRC_W;
  assign fetch_idx = accept ? bus.req_sel : idx_wrap[SEL_BITS-1:0];
  assign fetch_oor = ({1'b0, fetch_idx} >= NR_SRC_W);

  // Indices with no backing source fall through the loop and read as zero.
  always_comb begin
    fetch_data = '0;
    for (int i = 0; i < NR_OF_SOURCES; i++) begin
      if (fetch_idx == SEL_BITS'(i)) begin
        fetch_data = reg_in_i[i*NR_OF_BITS +: NR_OF_BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_XFER;
          cnt_d   = bus.req_len;
          data_d  = fetch_data;
          idx_d   = fetch_idx;
          valid_d = 1'b1;
          last_d  = (bus.req_len == '0);
          err_d   = err_q | fetch_oor;
        end
      end
      default: begin
        if (consume) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            data_d  = fetch_data;
            idx_d   = fetch_idx;
            last_d  = (cnt_q == LEN_BITS'(1));
            err_d   = err_q | fetch_oor;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.sel_error = err_q;

endmodule

// File: doc/operand_fetch_sel.md
OPERAND_FETCH_SEL -- requirements
Module: operand_fetch_sel

Interface
REQ-001 nrOfBits, 16, data width of each source register and of the output.
REQ-002 nrOfSources, 8, number of selectable source registers (2..16).
REQ-003 selBits, 3, width of the source index; the design SHALL satisfy 2^selBits >= nrOfSources.
REQ-004 lenBits, 3, width of the burst length field.
REQ-005 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-007 regIn  in  nrOfSources*nrOfBits  flattened sources; source i occupies bits [i*nrOfBits +: nrOfBits].
REQ-008 reqValid  in  1  request present.
REQ-009 reqReady  out  1  block can accept a request.
REQ-010 reqSel  in  selBits  start source index.
REQ-011 reqLen  in  lenBits  burst length minus one (0 = single fetch).
REQ-012 outData  out  nrOfBits  registered selected operand.
REQ-013 outValid  out  1  outData is valid.
REQ-014 outReady  in  1  consumer accepts outData.
REQ-015 outLast  out  1  current beat is the final beat of the burst.
REQ-016 outIdx  out  selBits  source index of the current beat.
REQ-017 selError  out  1  sticky flag: an out-of-range index was fetched.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and XFER.
REQ-019 reqReady SHALL be 1 in IDLE and 0 in XFER.
REQ-020 A request SHALL be accepted on an edge where reqValid=1 and reqReady=1; on that edge the FSM SHALL enter XFER, load the beat counter with reqLen, and register outData=regIn[reqSel], outIdx=reqSel and outValid=1 (one-cycle latency from acceptance to first beat).
REQ-021 A beat SHALL be consumed on an edge where outValid=1 and outReady=1.
REQ-022 While outValid=1 and outReady=0, outData, outIdx and outLast SHALL hold stable, even if regIn changes.
REQ-023 On consumption of a beat that is not the last, the next index SHALL be (outIdx+1) mod nrOfSources, sampled from regIn on that same edge, with the counter decremented; there SHALL be no bubble between beats.
REQ-024 outLast SHALL be 1 exactly when the beat counter equals 0.
REQ-025 On consumption of the last beat, the FSM SHALL return to IDLE with outValid=0; a new request SHALL be acceptable on the following edge, never on the same edge.
REQ-026 Index wrap: a burst starting at nrOfSources-1 SHALL continue at index 0.
REQ-027 If a fetched index is >= nrOfSources, outData SHALL be 0 for that beat and selError SHALL set to 1 on the same edge; selError SHALL clear only on reset.
REQ-028 Bursts longer than nrOfSources SHALL re-fetch sources cyclically, with each beat's value sampled at its own load edge.
REQ-029 In XFER, reqValid SHALL be ignored and SHALL have no effect on state.

Reset
REQ-030 While reset=1 at a rising edge: FSM=IDLE, outValid=0, outLast=0, outData=0, outIdx=0, selError=0, beat counter=0.
REQ-031 Reset SHALL take priority over all other events, including a reset asserted mid-burst; any in-flight burst SHALL be abandoned without further beats.
REQ-032 On the first edge after reset deasserts, reqReady SHALL be 1 and a request SHALL be accepted.

Verification
REQ-033 Single fetch: regIn[3]=0xBEEF, reqSel=3, reqLen=0, outReady=1 -> the next cycle shows outData=0xBEEF, outIdx=3, outLast=1, outValid=1; the cycle after shows outValid=0 and reqReady=1.
REQ-034 Wrap burst: reqSel=6, reqLen=3, outReady=1 -> four consecutive beats with outIdx 6,7,0,1, outLast only on the 4th beat.
REQ-035 Backpressure: during a burst, hold outReady=0 for 3 cycles and change regIn[idx] -> outData and outIdx stay stable; the new value of the next index appears after release.
REQ-036 Out-of-range: nrOfSources=6, reqSel=5, reqLen=1 -> beat0 has idx 5 with regIn[5]; beat1 has idx 0 (wrap), and selError stays 0. Separately, reqSel=7 -> outData=0 and selError=1, which persists until reset.
REQ-037 Reset mid-burst: reqLen=7, assert reset after 2 beats -> the next cycle shows outValid=0, reqReady=1, selError=0; a new request is accepted on the first edge after reset deasserts.
REQ-038 Back-to-back: a request is held valid across the last-beat consumption -> it is not accepted on that edge; it is accepted on the next edge.
